// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: glitch-filters a multiplexed common-anode 7-segment bus and rebuilds hex nibbles.
// Optional macro SEG7_SCAN_DP_EN adds the per-digit decimal point (dp_in / dp_out).
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    clear,
`ifdef SEG7_SCAN_DP_EN
    input  logic                    dp_in,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_out,
    output logic                    err_pattern,
    output logic                    err_anode
);

`ifdef SEG7_SCAN_DP_EN
    localparam int SW = NUM_DIGITS + 8;
`else
    localparam int SW = NUM_DIGITS + 7;
`endif
    localparam int             CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

    // Active-low common-anode codes; bit 4 of the result flags a legal hex digit.
    function automatic logic [4:0] hex_decode(input logic [6:0] s);
        case (s)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    logic [SW-1:0]           samp_d, samp_q;
    logic [CW-1:0]           cnt_d, cnt_q;
    logic                    done_d, done_q;
    logic [NUM_DIGITS-1:0]   seen_d, seen_q;
    logic [4*NUM_DIGITS-1:0] value_d, value_q;
    logic [NUM_DIGITS-1:0]   valid_d, valid_q;
    logic                    fvalid_d, fvalid_q;
    logic [4*NUM_DIGITS-1:0] frame_d, frame_q;
    logic                    errp_d, errp_q;
    logic                    erra_d, erra_q;
`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0]   dp_d, dp_q;
    logic                    dp_s;
`endif

    logic [6:0]            seg_s;
    logic [NUM_DIGITS-1:0] anode_low;
    logic                  none_low;
    logic                  one_low;
    logic                  multi_low;
    logic                  commit;
    logic                  frame_fire;
    logic [4:0]            dec;
    logic                  legal;
    logic                  blank;

`ifdef SEG7_SCAN_DP_EN
    assign samp_d = {dp_in, an_in, seg_in};
    assign dp_s   = samp_q[SW-1];
`else
    assign samp_d = {an_in, seg_in};
`endif

    // Everything downstream of the filter looks only at the registered sample.
    assign seg_s      = samp_q[6:0];
    assign anode_low  = ~samp_q[7 +: NUM_DIGITS];
    assign none_low   = (anode_low == '0);
    assign one_low    = !none_low && ((anode_low & (anode_low - 1'b1)) == '0);
    assign multi_low  = !none_low && !one_low;
    assign dec        = hex_decode(seg_s);
    assign legal      = dec[4];
    assign blank      = (seg_s == 7'b1111111);
    assign commit     = (cnt_q == CNT_MAX) && !done_q;
    assign frame_fire = &seen_q;

    always_comb begin
        if (samp_d != samp_q) begin
            cnt_d  = CW'(1);
            done_d = 1'b0;
        end else begin
            cnt_d  = (cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
            done_d = done_q | commit;
        end

        value_d  = value_q;
        valid_d  = valid_q;
        seen_d   = frame_fire ? '0 : seen_q;
        fvalid_d = frame_fire;
        frame_d  = frame_fire ? value_q : frame_q;
        errp_d   = errp_q;
        erra_d   = erra_q;
`ifdef SEG7_SCAN_DP_EN
        dp_d     = dp_q;
`endif

        if (commit && multi_low) begin
            erra_d = 1'b1;
        end
        if (commit && one_low && !legal && !blank) begin
            errp_d = 1'b1;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && one_low && anode_low[i]) begin
                if (legal) begin
                    value_d[4*i +: 4] = dec[3:0];
                    valid_d[i]        = 1'b1;
                    seen_d[i]         = 1'b1;
`ifdef SEG7_SCAN_DP_EN
                    dp_d[i]           = ~dp_s;
`endif
                end else if (blank) begin
                    valid_d[i]        = 1'b0;
                    seen_d[i]         = 1'b1;
`ifdef SEG7_SCAN_DP_EN
                    dp_d[i]           = ~dp_s;
`endif
                end else begin
                    valid_d[i]        = 1'b0;
                end
            end
        end

        // Clear dominates any commit or frame pulse landing on the same edge.
        if (clear) begin
            cnt_d    = '0;
            done_d   = 1'b0;
            value_d  = '0;
            valid_d  = '0;
            seen_d   = '0;
            fvalid_d = 1'b0;
            frame_d  = '0;
            errp_d   = 1'b0;
            erra_d   = 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            seen_q   <= '0;
            value_q  <= '0;
            valid_q  <= '0;
            fvalid_q <= 1'b0;
            frame_q  <= '0;
            errp_q   <= 1'b0;
            erra_q   <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_q     <= '0;
`endif
        end else begin
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            seen_q   <= seen_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            fvalid_q <= fvalid_d;
            frame_q  <= frame_d;
            errp_q   <= errp_d;
            erra_q   <= erra_d;
`ifdef SEG7_SCAN_DP_EN
            dp_q     <= dp_d;
`endif
        end
    end

    assign value_out   = value_q;
    assign digit_valid = valid_q;
    assign frame_valid = fvalid_q;
    assign frame_out   = frame_q;
    assign err_pattern = errp_q;
    assign err_anode   = erra_q;
`ifdef SEG7_SCAN_DP_EN
    assign dp_out      = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4) with an expected-value queue.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        clear;
    logic [15:0] value_out;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic [15:0] frame_out;
    logic        err_pattern;
    logic        err_anode;
`ifdef SEG7_SCAN_DP_EN
    logic        dp_in;
    logic [3:0]  dp_out;
`endif

    int          tests = 0;
    int          fails = 0;
    int          frame_cnt = 0;
    int          chg_cnt = 0;
    int          chg_base;
    logic [15:0] last_frame = '0;
    logic [19:0] prev_obs = '0;
    logic [31:0] exp_q[$];

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .clear       (clear),
`ifdef SEG7_SCAN_DP_EN
        .dp_in       (dp_in),
        .dp_out      (dp_out),
`endif
        .value_out   (value_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .frame_out   (frame_out),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    always #5 clk = ~clk;

    // Observes frame pulses and output changes away from the active edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            frame_cnt++;
            last_frame = frame_out;
        end
        if ({value_out, digit_valid} !== prev_obs) chg_cnt++;
        prev_obs = {value_out, digit_valid};
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        clear  = 1'b0;
        an_in  = 4'hF;
        seg_in = 7'h7F;
`ifdef SEG7_SCAN_DP_EN
        dp_in  = 1'b1;
`endif

        // 1: reset with random bus activity, then a stretch one sample too short
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            an_in  = 4'($urandom_range(0, 15));
            seg_in = 7'($urandom_range(0, 127));
        end
        @(negedge clk);
        push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        check("rst_value", 32'(value_out));
        check("rst_valid", 32'(digit_valid));
        check("rst_frame_valid", 32'(frame_valid));
        check("rst_frame_out", 32'(frame_out));
        check("rst_err_pattern", 32'(err_pattern));
        check("rst_err_anode", 32'(err_anode));
        rst_n = 1'b1;
        hold(4'b1110, 7'b1111001, 3);
        hold(4'b1111, 7'b1111111, 3);
        push(32'h0); push(32'h0);
        check("short_value", 32'(value_out));
        check("short_valid", 32'(digit_valid));

        // 2: commit latency is exactly STABLE_CYCLES edges after first sample
        chg_base = chg_cnt;
        push(32'h0); push(32'h2); push(32'h1); push(32'h1); push(32'h0);
        hold(4'b1110, 7'b0100100, 4);
        check("lat_before", 32'(value_out[3:0]));
        hold(4'b1110, 7'b0100100, 1);
        check("lat_nibble", 32'(value_out[3:0]));
        check("lat_valid", 32'(digit_valid));
        hold(4'b1110, 7'b0100100, 1);
        hold(4'b1111, 7'b1111111, 2);
        check("lat_one_commit", 32'(chg_cnt - chg_base));
        check("lat_no_frame", 32'(frame_cnt));

        // 3: two full scans of 1,2,A,F -> one frame each
        push(32'h1); push(32'hFA21); push(32'hF); push(32'hFA21);
        hold(4'b1110, 7'b1111001, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b1101, 7'b0100100, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b1011, 7'b0001000, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b0111, 7'b0001110, 8); hold(4'b1111, 7'b1111111, 2);
        check("scan1_frames", 32'(frame_cnt));
        check("scan1_frame_data", 32'(last_frame));
        check("scan1_valid", 32'(digit_valid));
        check("scan1_value", 32'(value_out));
        push(32'h2); push(32'hFA21); push(32'h0);
        hold(4'b1110, 7'b1111001, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b1101, 7'b0100100, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b1011, 7'b0001000, 8); hold(4'b1111, 7'b1111111, 2);
        hold(4'b0111, 7'b0001110, 8); hold(4'b1111, 7'b1111111, 2);
        check("scan2_frames", 32'(frame_cnt));
        check("scan2_frame_out", 32'(frame_out));
        check("scan2_pulse_ended", 32'(frame_valid));

        // blank digit: clears its valid bit, keeps the nibble
        push(32'hB); push(32'hFA21);
        hold(4'b1011, 7'b1111111, 8); hold(4'b1111, 7'b1111111, 2);
        check("blank_valid", 32'(digit_valid));
        check("blank_value", 32'(value_out));

        // 4: two-sample glitch to a legal '8' is filtered out
        push(32'h5); push(32'h5); push(32'h0); push(32'h0);
        hold(4'b1110, 7'b0010010, 8);
        check("glitch_pre", 32'(value_out[3:0]));
        hold(4'b1110, 7'b0000000, 2);
        hold(4'b1110, 7'b0010010, 8);
        check("glitch_post", 32'(value_out[3:0]));
        check("glitch_err_pattern", 32'(err_pattern));
        check("glitch_err_anode", 32'(err_anode));

        // 5: illegal pattern, multi-anode, then clear
        push(32'h1); push(32'h9); push(32'h2); push(32'h0);
        hold(4'b1111, 7'b1111111, 2);
        hold(4'b1101, 7'b1010101, 8);
        check("illegal_err_pattern", 32'(err_pattern));
        check("illegal_valid", 32'(digit_valid));
        check("illegal_nibble1", 32'(value_out[7:4]));
        check("illegal_err_anode", 32'(err_anode));
        push(32'h1); push(32'h9); push(32'h2);
        hold(4'b1100, 7'b1111001, 8);
        check("multi_err_anode", 32'(err_anode));
        check("multi_valid", 32'(digit_valid));
        check("frames_before_clear", 32'(frame_cnt));
        hold(4'b1111, 7'b1111111, 2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0); push(32'h0);
        check("clr_value", 32'(value_out));
        check("clr_valid", 32'(digit_valid));
        check("clr_frame_out", 32'(frame_out));
        check("clr_frame_valid", 32'(frame_valid));
        check("clr_err_pattern", 32'(err_pattern));
        check("clr_err_anode", 32'(err_anode));
        hold(4'b1111, 7'b1111111, 3);

`ifdef SEG7_SCAN_DP_EN
        // 6: decimal point captured with the digit
        push(32'h8); push(32'h1); push(32'h8); push(32'h0);
        dp_in = 1'b0;
        hold(4'b1110, 7'b0000000, 8);
        check("dp_on_value", 32'(value_out[3:0]));
        check("dp_on", 32'(dp_out[0]));
        dp_in = 1'b1;
        hold(4'b1111, 7'b1111111, 2);
        hold(4'b1110, 7'b0000000, 8);
        check("dp_off_value", 32'(value_out[3:0]));
        check("dp_off", 32'(dp_out[0]));
`endif

        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expect: %0d expected values never compared, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
